// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, image limits and window-fetch state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cnn_pkg;

   localparam int DATA_SIZE      = 16;
   localparam int KERNEL         = 5;
   localparam int BLOCK_SIZE     = KERNEL * KERNEL;
   localparam int BUF_ADDR_SIZE  = 10;
   localparam int IMG_SIZE_WIDTH = 16;
   localparam int MAX_IMG_SIDE   = 32;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      SHIFT,
      PRESENT,
      DONE
   } win_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Maps a window origin plus tap (r,c) to an image-buffer word address and an in-bounds flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs. Build option WINDOW_ZERO_PAD_EN shifts the origin by (-2,-2).
module window_addr_gen import cnn_pkg::*; (
   input  logic [IMG_SIZE_WIDTH-1:0] row,
   input  logic [IMG_SIZE_WIDTH-1:0] col,
   input  logic [2:0]                tap_r,
   input  logic [2:0]                tap_c,
   input  logic [IMG_SIZE_WIDTH-1:0] size,
   output logic [BUF_ADDR_SIZE-1:0]  addr,
   output logic                      in_bounds
);

   localparam int AW = 2 * IMG_SIZE_WIDTH;

`ifdef WINDOW_ZERO_PAD_EN
   // "same" windows are centred on the output pixel
   localparam logic signed [AW:0] ORIGIN_OFF = (AW+1)'(KERNEL / 2);
`else
   localparam logic signed [AW:0] ORIGIN_OFF = '0;
`endif

   logic signed [AW:0] img_row;
   logic signed [AW:0] img_col;
   logic signed [AW:0] size_s;

   // signed image coordinates so padded taps can fall above/left of the image
   always_comb begin
      size_s    = $signed({{(AW+1-IMG_SIZE_WIDTH){1'b0}}, size});
      img_row   = $signed({{(AW+1-IMG_SIZE_WIDTH){1'b0}}, row})
                + $signed({{(AW-2){1'b0}}, tap_r}) - ORIGIN_OFF;
      img_col   = $signed({{(AW+1-IMG_SIZE_WIDTH){1'b0}}, col})
                + $signed({{(AW-2){1'b0}}, tap_c}) - ORIGIN_OFF;
      in_bounds = !img_row[AW] && !img_col[AW] && (img_row < size_s) && (img_col < size_s);
      addr      = BUF_ADDR_SIZE'(img_row * size_s + img_col);
   end

endmodule

// File: rtl/window_fetch.sv
// Walks a size x size image in raster order and presents every 5x5 stride-1 window (FILL 25 reads, SHIFT 5 reads).
// Latency: first window start+27; next window 6 cycles after handshake on a horizontal step, 26 on a row change.
// Backpressure: win/win_row/win_col held with win_valid until win_ready. Build option WINDOW_ZERO_PAD_EN selects "same" padding.
module window_fetch import cnn_pkg::*; (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [IMG_SIZE_WIDTH-1:0]             size,
   output logic [BUF_ADDR_SIZE-1:0]              buf_addr,
   input  logic [DATA_SIZE-1:0]                  buf_data,
   output logic [BLOCK_SIZE-1:0][DATA_SIZE-1:0]  win,
   output logic                                  win_valid,
   input  logic                                  win_ready,
   output logic [IMG_SIZE_WIDTH-1:0]             win_row,
   output logic [IMG_SIZE_WIDTH-1:0]             win_col,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err
);

   localparam int              TAP_W      = $clog2(BLOCK_SIZE + 1);
   // FILL/SHIFT end on a capture-only cycle once the counter reaches the read count
   localparam logic [TAP_W-1:0] FILL_LAST  = TAP_W'(BLOCK_SIZE);
   localparam logic [TAP_W-1:0] SHIFT_LAST = TAP_W'(KERNEL);
   localparam logic [2:0]       EDGE       = 3'(KERNEL - 1);

   win_state_t                state;
   logic [IMG_SIZE_WIDTH-1:0] size_q;
   logic [IMG_SIZE_WIDTH-1:0] last_idx;
   logic [TAP_W-1:0]          cnt;
   logic [2:0]                ir;
   logic [2:0]                ic;
   logic [BUF_ADDR_SIZE-1:0]  addr_q;
   logic                      cap_vld;
   logic                      cap_zero;
   logic [TAP_W-1:0]          cap_tap;

   logic                      too_big;
   logic                      empty;
   logic [IMG_SIZE_WIDTH-1:0] new_last;
   logic                      hs;
   logic                      last_win;
   logic                      step_right;
   logic                      iss_vld;
   logic [2:0]                iss_r;
   logic [2:0]                iss_c;
   logic [IMG_SIZE_WIDTH-1:0] iss_row;
   logic [IMG_SIZE_WIDTH-1:0] iss_col;
   logic [TAP_W-1:0]          iss_tap;
   logic [BUF_ADDR_SIZE-1:0]  gen_addr;
   logic                      gen_inb;

   // qualify a requested pass from its size (output side and last origin index)
   always_comb begin
      too_big  = (size > IMG_SIZE_WIDTH'(MAX_IMG_SIDE));
`ifdef WINDOW_ZERO_PAD_EN
      empty    = (size == '0);
      new_last = size - IMG_SIZE_WIDTH'(1);
`else
      empty    = (size < IMG_SIZE_WIDTH'(KERNEL));
      new_last = size - IMG_SIZE_WIDTH'(KERNEL);
`endif
   end

   // read issue: the handshake cycle already issues the first read of the next window
   always_comb begin
      hs         = (state == PRESENT) && win_valid && win_ready;
      last_win   = (win_row == last_idx) && (win_col == last_idx);
      step_right = (win_col != last_idx);
      iss_vld    = 1'b0;
      iss_r      = ir;
      iss_c      = ic;
      iss_row    = win_row;
      iss_col    = win_col;
      case (state)
         FILL:  iss_vld = (cnt < FILL_LAST);
         SHIFT: begin
            iss_vld = (cnt < SHIFT_LAST);
            iss_c   = EDGE;
         end
         PRESENT: begin
            if (hs && !last_win) begin
               iss_vld = 1'b1;
               iss_r   = '0;
               if (step_right) begin
                  iss_c   = EDGE;
                  iss_col = win_col + IMG_SIZE_WIDTH'(1);
               end else begin
                  iss_c   = '0;
                  iss_row = win_row + IMG_SIZE_WIDTH'(1);
                  iss_col = '0;
               end
            end
         end
         default: ;
      endcase
      iss_tap  = TAP_W'(iss_r) * TAP_W'(KERNEL) + TAP_W'(iss_c);
      // padded taps issue no read, so the address simply holds
      buf_addr = (iss_vld && gen_inb) ? gen_addr : addr_q;
   end

   window_addr_gen u_addr_gen (
      .row       (iss_row),
      .col       (iss_col),
      .tap_r     (iss_r),
      .tap_c     (iss_c),
      .size      (size_q),
      .addr      (gen_addr),
      .in_bounds (gen_inb)
   );

   // control FSM, tap shift/capture and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         size_q    <= '0;
         last_idx  <= '0;
         cnt       <= '0;
         ir        <= '0;
         ic        <= '0;
         addr_q    <= '0;
         cap_vld   <= 1'b0;
         cap_zero  <= 1'b0;
         cap_tap   <= '0;
         win       <= '0;
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         addr_q   <= buf_addr;
         cap_vld  <= iss_vld;
         cap_tap  <= iss_tap;
         cap_zero <= !gen_inb;
         done     <= 1'b0;

         if (hs && !last_win && step_right) begin
            for (int r = 0; r < KERNEL; r++) begin
               for (int c = 0; c < KERNEL - 1; c++) begin
                  win[r*KERNEL + c] <= win[r*KERNEL + c + 1];
               end
            end
         end

         for (int t = 0; t < BLOCK_SIZE; t++) begin
            if (cap_vld && (cap_tap == TAP_W'(t))) begin
               win[t] <= cap_zero ? '0 : buf_data;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  size_q   <= size;
                  last_idx <= new_last;
                  err      <= too_big;
                  busy     <= 1'b1;
                  win_row  <= '0;
                  win_col  <= '0;
                  cnt      <= '0;
                  ir       <= '0;
                  ic       <= '0;
                  if (too_big || empty) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            FILL: begin
               if (cnt == FILL_LAST) begin
                  state     <= PRESENT;
                  win_valid <= 1'b1;
               end else begin
                  cnt <= cnt + TAP_W'(1);
                  if (ic == EDGE) begin
                     ic <= '0;
                     ir <= ir + 3'd1;
                  end else begin
                     ic <= ic + 3'd1;
                  end
               end
            end
            SHIFT: begin
               if (cnt == SHIFT_LAST) begin
                  state     <= PRESENT;
                  win_valid <= 1'b1;
               end else begin
                  cnt <= cnt + TAP_W'(1);
                  ir  <= ir + 3'd1;
               end
            end
            PRESENT: begin
               if (hs) begin
                  win_valid <= 1'b0;
                  if (last_win) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (step_right) begin
                     state   <= SHIFT;
                     win_col <= win_col + IMG_SIZE_WIDTH'(1);
                     cnt     <= TAP_W'(1);
                     ir      <= 3'd1;
                     ic      <= EDGE;
                  end else begin
                     state   <= FILL;
                     win_row <= win_row + IMG_SIZE_WIDTH'(1);
                     win_col <= '0;
                     cnt     <= TAP_W'(1);
                     ir      <= '0;
                     ic      <= 3'd1;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/window_fetch.md
# window_fetch

Downstream neighbour of the block loader in the CNN datapath. Once the loader has filled the 1024-word image buffer with a `size` × `size` image (row-major, word address = row·size + col), this block walks the image in raster order. It reads the image through a single synchronous read port and presents each 5×5 stride-1 window as a 25-word bundle to the convolution unit over a valid/ready handshake. Horizontal steps reuse 20 taps and fetch only the new 5-tap column.

## Interface
- `DATA_SIZE`, 16, word width
- `IMG_SIZE_WIDTH`, 16, width of `size`
- `BUF_ADDR_SIZE`, 10, image buffer address width (1024 words)
- `KERNEL`, 5, window side; `BLOCK_SIZE` = KERNEL·KERNEL = 25
- `clk`  in  1  sole clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a pass; sampled only in IDLE
- `size`  in  IMG_SIZE_WIDTH  image side; sampled with `start`
- `buf_addr`  out  BUF_ADDR_SIZE  image buffer read address
- `buf_data`  in  DATA_SIZE  read data, valid one cycle after `buf_addr`
- `win`  out  DATA_SIZE × BLOCK_SIZE  window, tap r·5+c = image(row+r, col+c)
- `win_valid`  out  1  window presented
- `win_ready`  in  1  consumer accepts
- `win_row`, `win_col`  out  IMG_SIZE_WIDTH each  window origin
- `busy`  out  1  high from the cycle after `start` until `done`
- `done`  out  1  one-cycle pulse at end of pass
- `err`  out  1  set when `size` > 32; cleared by next accepted `start` or `rst`

## Operation
- States: IDLE, FILL, SHIFT, PRESENT, DONE.
- IDLE + `start`:
  - Latch `size`.
  - If `size` > 32, set `err` and go to DONE.
  - Else, if the output side (size−4, or size with padding) is < 1, go to DONE.
  - Else go to FILL at origin (0,0).
- FILL: issues 25 reads, one per cycle, in tap order. Each returned word is captured into its tap on the following cycle. Goes to PRESENT after the 25th capture.
- PRESENT: `win_valid`=1. `win`, `win_row`, `win_col` are held stable until `win_ready`. Handshake cycle (`win_valid` & `win_ready`), in priority order:
  - last window → DONE
  - col < last col → SHIFT (col+1)
  - otherwise → FILL (row+1, col 0)
- SHIFT: taps shift one column left (tap c ← tap c+1). Issues 5 reads for column col+4, rows row..row+4, and captures them into taps 4, 9, 14, 19, 24.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Address arithmetic: (row+r)·size + (col+c) computed at 2·IMG_SIZE_WIDTH, then truncated to BUF_ADDR_SIZE. `size` ≤ 32 guarantees no truncation.
- Outside FILL/SHIFT, `buf_addr` holds its last value.

## Timing
- Reset values: `buf_addr`=0, `win` all 0, `win_valid`=0, `win_row`=`win_col`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- `start` in cycle T: first read address in T+1; first `win_valid` in T+27 (25 issue + 1 latency + 1 register).
- Horizontal step: 6 cycles from handshake to next `win_valid`.
- Row change: 26 cycles from handshake to next `win_valid`.
- DONE for empty/error passes: `done` in T+1.
- Last handshake in cycle H: `done` in H+1, `busy` low in H+2.
- `rst` in any state: all outputs to reset values next cycle, and the pass is abandoned.

## Configuration
- `WINDOW_ZERO_PAD_EN` defined: "same" padding.
  - Output side = size; window origin offset is (−2,−2).
  - Taps outside the image take value 0 and issue no read. The cycle is still spent, so the cycle counts above are unchanged.
  - `size` 1..32 produces windows.
- Undefined: "valid" mode only. Output side = size−4; `size` < 5 gives zero windows.

## Structure
- Shared package `cnn_pkg` holds:
  - `DATA_SIZE`, `KERNEL`, `BLOCK_SIZE`, `BUF_ADDR_SIZE`, `IMG_SIZE_WIDTH`
  - `MAX_IMG_SIDE`=32
  - the `win_state_t` enum (IDLE, FILL, SHIFT, PRESENT, DONE)
- One sub-module, `window_addr_gen`: combinational mapping from origin, tap (r,c) and size to `buf_addr` plus an in-bounds flag. It is shared by FILL and SHIFT.

## Test plan
- Valid mode, size=5, buffer word n = n: exactly one window, `win[i]`=i, `win_valid` at T+27, `done` one cycle after handshake.
- Valid mode, size=6, buffer word n = n:
  - windows emitted in order (0,0),(0,1),(1,0),(1,1)
  - window (0,1): `win[0]`=1, `win[24]`=29
  - gap after the first handshake is 6 cycles; gap after the second handshake is 26 cycles
- Backpressure, size=6: `win_ready` held low for 10 cycles at window (0,0) → `win`, `win_row`, `win_col`, `buf_addr` unchanged, `win_valid` held.
- size=4:
  - without `WINDOW_ZERO_PAD_EN`: `done` at T+1, no `win_valid`
  - with it: 16 windows; window (0,0) has `win[12]`=image(0,0)=0, `win[18]`=5, `win[0..11]`=0
- size=33 → `err`=1 and `done` at T+1, no reads. A later `start` with size=5 clears `err`.
- `rst` asserted mid-FILL (size=6, cycle T+10) → all outputs at reset values the next cycle. A following `start` completes a normal pass.
